// File: rtl/simon_sequencer.sv
// Simon game sequencer: grows an LFSR-derived colour sequence, plays it back
// through the lamp encoder and checks the player's button presses against it.
module simon_sequencer #(
    parameter int         MAX_LEN       = 16,
    parameter int         ON_TICKS      = 4,
    parameter int         OFF_TICKS     = 2,
    parameter int         TIMEOUT_TICKS = 20,
    parameter logic [7:0] LFSR_SEED     = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] btn,
    output logic       enc_oe,
    output logic [1:0] enc_colour,
    output logic [4:0] level,
    output logic       busy,
    output logic       win,
    output logic       fail
);

    localparam int TMAX_ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TMAX        = (TIMEOUT_TICKS > TMAX_ON_OFF) ? TIMEOUT_TICKS : TMAX_ON_OFF;
    localparam int TW          = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_ZERO   = TW'(0);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_TICKS - 1);
    localparam logic [4:0]    LEN_MAX  = 5'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADD      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_GAP      = 3'd5,
        S_WIN      = 3'd6,
        S_FAIL     = 3'd7
    } state_t;

    state_t          state_r;
    logic [7:0]      lfsr_r;
    logic [3:0]      idx_r;
    logic [TW-1:0]   timer_r;
    // Full 16-entry store so a 4-bit index never falls outside the array.
    logic [1:0]      seq_r [16];

    logic            btn_onehot_s;
    logic [1:0]      btn_colour_s;
    logic            last_s;
    logic [1:0]      exp_colour_s;

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting towards the MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Decode the press into a colour and flag whether exactly one button is down.
    always_comb begin
        btn_onehot_s = 1'b0;
        btn_colour_s = 2'b00;
        case (btn)
            4'b0001: begin btn_onehot_s = 1'b1; btn_colour_s = 2'b00; end
            4'b0010: begin btn_onehot_s = 1'b1; btn_colour_s = 2'b01; end
            4'b0100: begin btn_onehot_s = 1'b1; btn_colour_s = 2'b10; end
            4'b1000: begin btn_onehot_s = 1'b1; btn_colour_s = 2'b11; end
            default: begin btn_onehot_s = 1'b0; btn_colour_s = 2'b00; end
        endcase
    end

    // Position helpers for the playback/input walk.
    always_comb begin
        last_s       = ({1'b0, idx_r} == (level - 5'd1));
        exp_colour_s = seq_r[idx_r];
    end

    // Sequence store; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (state_r == S_ADD) begin
            seq_r[level[3:0]] <= lfsr_r[1:0];
        end
    end

    // Game FSM with registered encoder and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            lfsr_r     <= LFSR_SEED;
            idx_r      <= 4'd0;
            timer_r    <= T_ZERO;
            enc_oe     <= 1'b0;
            enc_colour <= 2'b00;
            level      <= 5'd0;
            busy       <= 1'b0;
            win        <= 1'b0;
            fail       <= 1'b0;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
            case (state_r)
                S_IDLE, S_WIN, S_FAIL: begin
                    if (start) begin
                        level   <= 5'd0;
                        win     <= 1'b0;
                        fail    <= 1'b0;
                        busy    <= 1'b1;
                        enc_oe  <= 1'b0;
                        state_r <= S_ADD;
                    end
                end
                S_ADD: begin
                    level   <= level + 5'd1;
                    idx_r   <= 4'd0;
                    timer_r <= ON_LOAD;
                    enc_oe  <= 1'b1;
                    // In round one entry 0 is being written this very cycle.
                    enc_colour <= (level == 5'd0) ? lfsr_r[1:0] : seq_r[0];
                    state_r <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (timer_r == T_ZERO) begin
                        timer_r <= OFF_LOAD;
                        enc_oe  <= 1'b0;
                        state_r <= S_SHOW_OFF;
                    end else begin
                        timer_r <= timer_r - T_ONE;
                    end
                end
                S_SHOW_OFF: begin
                    if (timer_r != T_ZERO) begin
                        timer_r <= timer_r - T_ONE;
                    end else if (last_s) begin
                        idx_r   <= 4'd0;
                        timer_r <= TO_LOAD;
                        state_r <= S_WAIT_IN;
                    end else begin
                        idx_r      <= idx_r + 4'd1;
                        timer_r    <= ON_LOAD;
                        enc_oe     <= 1'b1;
                        enc_colour <= seq_r[idx_r + 4'd1];
                        state_r    <= S_SHOW_ON;
                    end
                end
                S_WAIT_IN: begin
                    if (btn == 4'b0000) begin
                        if (timer_r == T_ZERO) begin
                            state_r    <= S_FAIL;
                            fail       <= 1'b1;
                            busy       <= 1'b0;
                            enc_oe     <= 1'b1;
                            enc_colour <= exp_colour_s;
                        end else begin
                            timer_r <= timer_r - T_ONE;
                        end
                    end else if (btn_onehot_s && (btn_colour_s == exp_colour_s)) begin
                        timer_r <= TO_LOAD;
                        if (!last_s) begin
                            idx_r <= idx_r + 4'd1;
                        end else if (level == LEN_MAX) begin
                            state_r <= S_WIN;
                            win     <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            timer_r <= OFF_LOAD;
                            state_r <= S_GAP;
                        end
                    end else begin
                        state_r    <= S_FAIL;
                        fail       <= 1'b1;
                        busy       <= 1'b0;
                        enc_oe     <= 1'b1;
                        enc_colour <= exp_colour_s;
                    end
                end
                S_GAP: begin
                    if (timer_r == T_ZERO) begin
                        state_r <= S_ADD;
                    end else begin
                        timer_r <= timer_r - T_ONE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    enc_oe  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer: table of round-one press scenarios plus
// hand-written reset, fail-hold, timer-reload and win sequences.
module tb_simon_sequencer;

    localparam int ON_T  = 4;
    localparam int OFF_T = 2;
    localparam int TO_T  = 20;
    localparam int MAXL  = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] btn;
    logic       enc_oe;
    logic [1:0] enc_colour;
    logic [4:0] level;
    logic       busy;
    logic       win;
    logic       fail;

    int passed = 0;
    int total  = 0;

    logic [7:0] m_lfsr;
    logic [1:0] mseq [16];
    int         mlevel;
    logic [3:0] b;

    // mode: 0 correct colour, 1 colour+1, 2 colour+2, 3 literal btn value
    typedef struct {
        int         mode;
        logic [3:0] lit;
        int         delay;
        bit         exp_fail;
        bit         exp_busy;
    } vec_t;

    vec_t vecs [8];

    simon_sequencer #(
        .MAX_LEN(MAXL), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T),
        .TIMEOUT_TICKS(TO_T), .LFSR_SEED(8'h01)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .btn(btn),
        .enc_oe(enc_oe), .enc_colour(enc_colour), .level(level),
        .busy(busy), .win(win), .fail(fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: feedback is the parity of taps 8,6,5,4 (mask 8'hB8).
    always @(posedge clk) begin
        m_lfsr <= rst ? 8'h01 : {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    function automatic logic [3:0] oh(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_oe"},     enc_oe,     0);
        chk({tag, "_colour"}, enc_colour, 0);
        chk({tag, "_level"},  level,      0);
        chk({tag, "_busy"},   busy,       0);
        chk({tag, "_win"},    win,        0);
        chk({tag, "_fail"},   fail,       0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; start = 1'b0; btn = 4'b0000;
        repeat (n) tick();
        rst = 1'b0;
        mlevel = 0;
    endtask

    // Pulse start; afterwards the DUT sits in ADD.
    task automatic begin_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        mlevel = 0;
        chk("add_busy", busy, 1);
        chk("add_level", level, 0);
    endtask

    // From ADD: capture the new colour, check full playback, stop on WAIT_IN cycle 1.
    task automatic play_round();
        mseq[mlevel] = m_lfsr[1:0];
        mlevel++;
        for (int i = 0; i < mlevel; i++) begin
            for (int t = 0; t < ON_T; t++) begin
                tick();
                chk($sformatf("on_oe_r%0d_i%0d", mlevel, i), enc_oe, 1);
                chk($sformatf("on_col_r%0d_i%0d", mlevel, i), enc_colour, mseq[i]);
                chk($sformatf("on_lvl_r%0d", mlevel), level, mlevel);
            end
            for (int t = 0; t < OFF_T; t++) begin
                tick();
                chk($sformatf("off_oe_r%0d_i%0d", mlevel, i), enc_oe, 0);
            end
        end
        tick();
        chk("wait_oe", enc_oe, 0);
        chk("wait_busy", busy, 1);
    endtask

    task automatic press(input logic [3:0] v);
        btn = v;
        tick();
        btn = 4'b0000;
    endtask

    task automatic answer_all();
        for (int i = 0; i < mlevel; i++) press(oh(mseq[i]));
    endtask

    // From GAP cycle 1 through to ADD.
    task automatic gap_to_add();
        chk("gap1_oe", enc_oe, 0);
        chk("gap1_busy", busy, 1);
        tick();
        chk("gap2_oe", enc_oe, 0);
        chk("gap2_busy", busy, 1);
        tick();
        chk("add_busy2", busy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; btn = 4'b0000; mlevel = 0;

        vecs[0] = '{0, 4'b0000, 0,  1'b0, 1'b1};
        vecs[1] = '{1, 4'b0000, 0,  1'b1, 1'b0};
        vecs[2] = '{2, 4'b0000, 3,  1'b1, 1'b0};
        vecs[3] = '{3, 4'b0011, 0,  1'b1, 1'b0};
        vecs[4] = '{3, 4'b1111, 5,  1'b1, 1'b0};
        vecs[5] = '{0, 4'b0000, 19, 1'b0, 1'b1};
        vecs[6] = '{3, 4'b0000, 18, 1'b0, 1'b1};
        vecs[7] = '{3, 4'b0000, 19, 1'b1, 1'b0};

        // Power-up reset, then reset from mid-game activity.
        do_reset(2);
        chk_zero("rst0");
        begin_game();
        play_round();
        press(oh(mseq[0]));
        tick();
        do_reset(2);
        chk_zero("rst1");

        // Reset during SHOW_ON clears everything on the next cycle.
        begin_game();
        tick();
        chk("show_oe", enc_oe, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("rst2");

        // Round-one press scenarios.
        for (int v = 0; v < 8; v++) begin
            do_reset(1);
            begin_game();
            play_round();
            repeat (vecs[v].delay) tick();
            case (vecs[v].mode)
                0:       b = oh(mseq[0]);
                1:       b = oh(mseq[0] + 2'd1);
                2:       b = oh(mseq[0] + 2'd2);
                default: b = vecs[v].lit;
            endcase
            press(b);
            chk($sformatf("vec%0d_fail", v), fail, vecs[v].exp_fail);
            chk($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
            chk($sformatf("vec%0d_oe", v), enc_oe, vecs[v].exp_fail);
            if (vecs[v].exp_fail) chk($sformatf("vec%0d_col", v), enc_colour, mseq[0]);
        end

        // FAIL holds against presses; start clears it.
        do_reset(1);
        begin_game();
        play_round();
        press(oh(mseq[0] + 2'd3));
        chk("f_fail", fail, 1);
        press(oh(mseq[0]));
        press(4'b1111);
        chk("f_hold_fail", fail, 1);
        chk("f_hold_busy", busy, 0);
        chk("f_hold_oe", enc_oe, 1);
        chk("f_hold_col", enc_colour, mseq[0]);
        chk("f_hold_lvl", level, 1);
        begin_game();
        chk("f_clr_fail", fail, 0);
        play_round();

        // Full game to WIN, with timeout-boundary presses and an ignored start.
        do_reset(1);
        begin_game();
        play_round();
        answer_all();
        gap_to_add();
        play_round();
        repeat (TO_T - 1) tick();
        press(oh(mseq[0]));
        chk("reload_fail1", fail, 0);
        chk("reload_busy1", busy, 1);
        repeat (TO_T - 1) tick();
        press(oh(mseq[1]));
        chk("reload_fail2", fail, 0);
        chk("reload_busy2", busy, 1);
        gap_to_add();
        play_round();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midstart_busy", busy, 1);
        chk("midstart_lvl", level, 3);
        answer_all();
        gap_to_add();
        play_round();
        answer_all();
        chk("win_win", win, 1);
        chk("win_busy", busy, 0);
        chk("win_lvl", level, 4);
        chk("win_oe", enc_oe, 0);
        chk("win_fail", fail, 0);
        press(4'b0001);
        chk("win_hold", win, 1);
        begin_game();
        chk("restart_win", win, 0);
        play_round();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
